imem_fetch_unit: RTL and testbench
==================================

# imem_fetch_unit

Parametrised, writable instruction memory for the RISC-V cores. It replaces fixed byte-array instruction storage with a word-organised store. Instructions are loaded at run time through a program-load port and fetched through a valid/ready request/response interface with a 2-entry response buffer, so a pipelined fetch stage can stall and flush. Every fetch response carries a fault code, so the pipeline detects misaligned, out-of-range and unloaded PCs without extra logic.

## Interface
- DEPTH_WORDS, 64, number of 32-bit instruction words stored (≥2)
- ADDR_WIDTH, 32, width of byte addresses on req_pc and prog_addr
- NOP_INSTR, 32'h00000013, instruction returned with any non-zero fault

- clk  in  1  sole clock, rising-edge
- reset  in  1  asynchronous, active-low; clears buffer, flags and per-word loaded bits
- req_valid  in  1  fetch request present
- req_ready  out  1  request accepted on this edge when both high
- req_pc  in  ADDR_WIDTH  byte address of instruction
- rsp_valid  out  1  head of response buffer valid
- rsp_ready  in  1  consumer takes head on this edge when both high
- rsp_instr  out  32  instruction, little-endian {byte3,byte2,byte1,byte0}
- rsp_pc  out  ADDR_WIDTH  PC of the returned instruction
- rsp_fault  out  2  0 ok, 1 misaligned, 2 out of range, 3 word never fully loaded
- flush  in  1  discard all buffered responses (branch redirect)
- prog_we  in  1  program-load write strobe
- prog_be  in  4  byte enables, bit i → byte i of the word
- prog_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored
- prog_data  in  32  write data, little-endian
- prog_err  out  1  one-cycle pulse: last write targeted an out-of-range word

## Operation
- Storage: DEPTH_WORDS × 32-bit words, plus one loaded bit per word. The word index is addr[ADDR_WIDTH-1:2].
- Word contents are not reset. The loaded bits reset to 0.
- Program write: on an edge with prog_we=1 and an in-range index, the selected bytes are written.
  - The loaded bit is set only when prog_be==4'b1111.
  - A partial write leaves the loaded bit unchanged.
- An out-of-range program write changes no state and sets prog_err=1 for the next cycle only.
- Fault priority, evaluated at accept: misaligned (pc[1:0]≠0) > out of range (index ≥ DEPTH_WORDS) > unloaded (loaded bit 0).
  - Any fault: rsp_instr = NOP_INSTR.
  - No fault: rsp_instr = stored word.
- Response buffer: 2-entry FIFO of {instr, pc, fault}.
  - req_ready = (count<2) && !flush. There is no combinational path from rsp_ready to req_ready.
  - Accept (req_valid && req_ready): the memory is read and the entry is pushed on the same edge.
  - Pop (rsp_valid && rsp_ready): the head is removed.
  - Push and pop on the same edge: count unchanged, order preserved.
- flush=1: count→0 on the next edge, and no push happens that cycle. flush overrides a simultaneous pop.
- Read/write collision: a fetch accepted on the same edge as a program write to the same word returns the old contents and the old loaded bit.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - count=0, rsp_valid=0, prog_err=0, all loaded bits 0.
  - rsp_instr=NOP_INSTR, rsp_pc=0, rsp_fault=0. req_ready=1 once reset is released.
- Reset asserted mid-operation: buffered responses are lost and the loaded bits clear. Memory words keep their values but read as fault 3 until rewritten.
- Latency: a request accepted at edge t gives rsp_valid=1 after edge t. Responses are returned in order.
- Throughput: one fetch per cycle when rsp_ready is held high.
- With rsp_ready low, the unit accepts exactly 2 requests, then req_ready=0 until a pop. req_ready rises the cycle after the pop edge.
- rsp_* outputs are held stable while rsp_valid=1 and rsp_ready=0.
- prog_err is registered and high for exactly one cycle per offending write. Back-to-back offending writes hold it high.

## Test plan
- Reset, then 3 program writes (be=4'hF): words 0/1/2 = 32'h00100133, 32'h404182B3, 32'h00737433. Then fetch PC 0,4,8 with rsp_ready=1 → responses one cycle after each accept, same order, instr as written, fault 0.
- Fetch PC 2 → fault 1. Fetch PC 4*DEPTH_WORDS → fault 2. Fetch a never-written PC 12 → fault 3. All three return instr 32'h00000013.
- Hold rsp_ready=0 and issue 4 requests → req_ready drops after the 2nd accept. Raise rsp_ready → first two responses drain in order, then the remaining requests are accepted.
- Fill the buffer with 2 entries, then pulse flush together with rsp_ready=1 and req_valid=1 → next cycle rsp_valid=0, count 0, no request accepted during the flush cycle.
- Write be=4'b0011 data 32'hAAAA5555 to word 5, then fetch PC 20 → fault 3. Rewrite with be=4'hF → fetch returns 32'hAAAA5555 with fault 0.
- Program write to word DEPTH_WORDS → prog_err high for one cycle, no memory change. Fetch word 3 while writing word 3 on the same edge → old value returned. Assert reset mid-stream → rsp_valid drops immediately and word 3 subsequently reads as fault 3.

Source files
------------

// File: rtl/imem_fetch_unit.sv
// Writable word-organised instruction memory with a valid/ready fetch port
// and a 2-entry response buffer. Each response carries a fault code.
module imem_fetch_unit #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_pc,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_instr,
  output logic [ADDR_WIDTH-1:0] rsp_pc,
  output logic [1:0]            rsp_fault,
  input  logic                  flush,
  input  logic                  prog_we,
  input  logic [3:0]            prog_be,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [31:0]           prog_data,
  output logic                  prog_err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef struct packed {
    logic [31:0]           instr;
    logic [ADDR_WIDTH-1:0] pc;
    logic [1:0]            fault;
  } entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_ONE,
    OCC_FULL
  } occ_t;

  logic [31:0]            mem [0:DEPTH_WORDS-1];
  logic [DEPTH_WORDS-1:0] loaded;

  occ_t   occ, occ_next;
  entry_t slot0, slot1;
  entry_t new_entry;

  logic [ADDR_WIDTH-3:0] req_idx, prog_idx;
  logic [IDX_W-1:0]      req_slot, prog_slot;
  logic                  req_in_range, prog_in_range;
  logic                  push, pop;
  logic                  prog_addr_unused;

  assign req_idx       = req_pc[ADDR_WIDTH-1:2];
  assign prog_idx      = prog_addr[ADDR_WIDTH-1:2];
  assign req_slot      = req_idx[IDX_W-1:0];
  assign prog_slot     = prog_idx[IDX_W-1:0];
  assign req_in_range  = 64'(req_idx) < 64'(DEPTH_WORDS);
  assign prog_in_range = 64'(prog_idx) < 64'(DEPTH_WORDS);
  assign prog_addr_unused = ^prog_addr[1:0];

  // Fault priority: misaligned, then out of range, then unloaded.
  always_comb begin
    new_entry.pc    = req_pc;
    new_entry.instr = NOP_INSTR;
    new_entry.fault = 2'd0;
    if (req_pc[1:0] != 2'b00) begin
      new_entry.fault = 2'd1;
    end else if (!req_in_range) begin
      new_entry.fault = 2'd2;
    end else if (!loaded[req_slot]) begin
      new_entry.fault = 2'd3;
    end else begin
      new_entry.instr = mem[req_slot];
    end
  end

  // Memory words carry no reset; only the loaded bits do.
  always_ff @(posedge clk) begin
    if (prog_we && prog_in_range) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (prog_be[b]) mem[prog_slot][8*b +: 8] <= prog_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      loaded   <= '0;
      prog_err <= 1'b0;
    end else begin
      prog_err <= prog_we && !prog_in_range;
      if (prog_we && prog_in_range && prog_be == 4'hF) loaded[prog_slot] <= 1'b1;
    end
  end

  assign req_ready = (occ != OCC_FULL) && !flush;
  assign rsp_valid = (occ != OCC_EMPTY);
  assign push      = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) occ <= OCC_EMPTY;
    else        occ <= occ_next;
  end

  always_comb begin
    occ_next = occ;
    if (flush) begin
      occ_next = OCC_EMPTY;
    end else begin
      unique case (occ)
        OCC_EMPTY: if (push) occ_next = OCC_ONE;
        OCC_ONE: begin
          if (push && !pop)      occ_next = OCC_FULL;
          else if (pop && !push) occ_next = OCC_EMPTY;
        end
        OCC_FULL:  if (pop) occ_next = OCC_ONE;
        default:   occ_next = OCC_EMPTY;
      endcase
    end
  end

  // slot0 is the head; a push into a draining single entry lands straight in slot0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot0 <= '{instr: NOP_INSTR, pc: '0, fault: 2'd0};
      slot1 <= '{instr: NOP_INSTR, pc: '0, fault: 2'd0};
    end else if (!flush) begin
      if (push && (occ == OCC_EMPTY || (occ == OCC_ONE && pop))) slot0 <= new_entry;
      else if (pop && occ == OCC_FULL)                          slot0 <= slot1;
      if (push && occ == OCC_ONE && !pop) slot1 <= new_entry;
    end
  end

  assign rsp_instr = slot0.instr;
  assign rsp_pc    = slot0.pc;
  assign rsp_fault = slot0.fault;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed plus randomized bench for imem_fetch_unit against a queue-based
// reference model of the memory, loaded bits and response stream.
module tb_imem_fetch_unit;
  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [31:0] req_pc = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_instr, rsp_pc;
  logic [1:0]  rsp_fault;
  logic        flush = 1'b0;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_be = '0;
  logic [31:0] prog_addr = '0, prog_data = '0;
  logic        prog_err;

  always #5 clk = ~clk;

  imem_fetch_unit #(.DEPTH_WORDS(DEPTH), .ADDR_WIDTH(32), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
    .rsp_pc(rsp_pc), .rsp_fault(rsp_fault), .flush(flush),
    .prog_we(prog_we), .prog_be(prog_be), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_err(prog_err)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  fault;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] mem_m [DEPTH];
  bit          ld_m  [DEPTH];
  bit          perr_m;
  int          nvec, nfail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic rsp_t ref_fetch(input logic [31:0] pc);
    rsp_t r;
    int unsigned w = pc >> 2;
    r.pc = pc;
    r.instr = NOP;
    r.fault = 2'd0;
    if (pc[1:0] != 2'b00)  r.fault = 2'd1;
    else if (w >= DEPTH)   r.fault = 2'd2;
    else if (!ld_m[w])     r.fault = 2'd3;
    else                   r.instr = mem_m[w];
    return r;
  endfunction

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    bit rdy, acc, pop;
    rsp_t nr;
    int unsigned w;
    #1;
    rdy = (exp_q.size() < 2) && !flush;
    chk("req_ready", 32'(req_ready), 32'(rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() > 0));
    chk("prog_err", 32'(prog_err), 32'(perr_m));
    if (exp_q.size() > 0) begin
      chk("rsp_instr", rsp_instr, exp_q[0].instr);
      chk("rsp_pc", rsp_pc, exp_q[0].pc);
      chk("rsp_fault", 32'(rsp_fault), 32'(exp_q[0].fault));
    end
    acc = req_valid && rdy;
    pop = (exp_q.size() > 0) && rsp_ready;
    nr  = ref_fetch(req_pc);
    @(posedge clk);
    if (flush) exp_q.delete();
    else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(nr);
    end
    perr_m = 1'b0;
    if (prog_we) begin
      w = prog_addr >> 2;
      if (w < DEPTH) begin
        for (int b = 0; b < 4; b++)
          if (prog_be[b]) mem_m[w][8*b +: 8] = prog_data[8*b +: 8];
        if (prog_be == 4'hF) ld_m[w] = 1'b1;
      end else perr_m = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic prog(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
    prog_we = 1'b1; prog_addr = addr; prog_be = be; prog_data = data;
    step();
    prog_we = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc);
    req_valid = 1'b1; req_pc = pc;
    step();
    req_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_instr"}, rsp_instr, NOP);
    chk({tag, "_rsp_pc"}, rsp_pc, 32'd0);
    chk({tag, "_rsp_fault"}, 32'(rsp_fault), 32'd0);
    chk({tag, "_prog_err"}, 32'(prog_err), 32'd0);
  endtask

  initial begin
    logic [31:0] pcs [4];
    int idx;
    bit acc;
    nvec = 0; nfail = 0; perr_m = 1'b0;
    for (int i = 0; i < DEPTH; i++) ld_m[i] = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b1;

    prog(32'd0, 4'hF, 32'h00100133);
    prog(32'd4, 4'hF, 32'h404182B3);
    prog(32'd8, 4'hF, 32'h00737433);

    rsp_ready = 1'b1;
    fetch(32'd0); fetch(32'd4); fetch(32'd8); step();

    fetch(32'd2); fetch(4 * DEPTH); fetch(32'd12); step();

    pcs = '{32'd0, 32'd4, 32'd8, 32'd0};
    idx = 0;
    rsp_ready = 1'b0;
    for (int c = 0; c < 12 && idx < 4; c++) begin
      req_valid = 1'b1; req_pc = pcs[idx];
      rsp_ready = (c >= 4);
      acc = exp_q.size() < 2;
      step();
      if (acc) idx++;
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (3) step();

    rsp_ready = 1'b0;
    fetch(32'd0); fetch(32'd4);
    flush = 1'b1; rsp_ready = 1'b1; req_valid = 1'b1; req_pc = 32'd8;
    step();
    flush = 1'b0; req_valid = 1'b0;
    step();

    prog(32'd20, 4'b0011, 32'hAAAA5555);
    fetch(32'd20); step();
    prog(32'd20, 4'hF, 32'hAAAA5555);
    fetch(32'd20); step();

    prog(4 * DEPTH, 4'hF, 32'hDEADBEEF);
    step();
    prog(4 * DEPTH + 8, 4'hF, 32'h1);
    prog(4 * DEPTH + 12, 4'hF, 32'h2);
    step(); step();

    prog(32'd12, 4'hF, 32'h11111111);
    req_valid = 1'b1; req_pc = 32'd12;
    prog(32'd12, 4'hF, 32'h22222222);
    req_valid = 1'b0;
    fetch(32'd12); step();

    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_pc    = $urandom_range(0, DEPTH + 3) * 4;
      if ($urandom_range(0, 7) == 0) req_pc = req_pc | $urandom_range(1, 3);
      if ($urandom_range(0, 15) == 0) req_pc = $urandom;
      rsp_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      prog_we   = ($urandom_range(0, 2) == 0);
      prog_be   = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      prog_addr = $urandom_range(0, DEPTH + 3) * 4 + $urandom_range(0, 3);
      prog_data = $urandom;
      step();
    end
    req_valid = 1'b0; flush = 1'b0; prog_we = 1'b0; rsp_ready = 1'b1;
    step(); step();

    prog(32'd12, 4'hF, 32'h33333333);
    rsp_ready = 1'b0;
    fetch(32'd12); fetch(32'd0);
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    perr_m = 1'b0;
    for (int i = 0; i < DEPTH; i++) ld_m[i] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    rsp_ready = 1'b1;
    fetch(32'd12); step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
